// File: rtl/ctrl_pipe_stages.sv
// Control-word pipeline behind the main decoder: one register stage per downstream
// pipe stage, each with its own stall/flush, plus valid tracking and a hold-bubble counter.
module ctrl_pipe_stages #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             ctrl_in,
  input  logic                         valid_in,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  output logic [STAGES*WIDTH-1:0]      ctrl_out,
  output logic [STAGES-1:0]            valid_out,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [WIDTH-1:0]  ctrlReg [STAGES];
  logic [STAGES-1:0] validReg;
  logic [CNT_W-1:0]  bubbleCnt;

  logic [WIDTH-1:0]  srcCtrl [STAGES];
  logic [STAGES-1:0] srcValid;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] holdBubble;
  logic [3:0]        newBubbles;
  logic [CNT_W+3:0]  cntSum;

  // A stall anywhere downstream freezes every stage in front of it.
  always_comb begin
    hold = stall;
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  always_comb begin
    srcCtrl[0]  = ctrl_in;
    srcValid[0] = valid_in;
    for (int i = 1; i < STAGES; i++) begin
      srcCtrl[i]  = ctrlReg[i-1];
      srcValid[i] = validReg[i-1];
    end
  end

  // Stage i takes a bubble when the stage feeding it is frozen but it is free to move.
  always_comb begin
    holdBubble = '0;
    newBubbles = '0;
    for (int i = 1; i < STAGES; i++) begin
      holdBubble[i] = hold[i-1] & ~hold[i] & ~flush[i];
      newBubbles    = newBubbles + 4'(holdBubble[i]);
    end
  end

  always_comb begin
    cntSum = {4'b0, bubbleCnt} + (CNT_W+4)'(newBubbles);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        ctrlReg[i] <= '0;
      end
      validReg  <= '0;
      bubbleCnt <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush[i] || holdBubble[i]) begin
          ctrlReg[i]  <= '0;
          validReg[i] <= 1'b0;
        end else if (!hold[i]) begin
          // Invalid words carry an all-zero control word so no write enable leaks through.
          ctrlReg[i]  <= srcValid[i] ? srcCtrl[i] : '0;
          validReg[i] <= srcValid[i];
        end
      end
      if (cntSum > {4'b0, {CNT_W{1'b1}}}) begin
        bubbleCnt <= '1;
      end else begin
        bubbleCnt <= cntSum[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < STAGES; i++) begin
      ctrl_out[i*WIDTH +: WIDTH] = ctrlReg[i];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(validReg[i]);
    end
  end

  assign valid_out  = validReg;
  assign bubble_cnt = bubbleCnt;

endmodule

// File: tb/tb_ctrl_pipe_stages.sv
// Bench for ctrl_pipe_stages: directed test-plan sequence plus random traffic, checked by a
// stage-level reference model through an expected queue; a CNT_W=2 copy exercises saturation.
module tb_ctrl_pipe_stages;

  localparam int W  = 12;
  localparam int S  = 3;
  localparam int SW = S*W + S + 2 + 16 + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ctrl_in;
  logic           valid_in;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic [S*W-1:0] ctrlOut, satCtrlOut;
  logic [S-1:0]   validOut, satValidOut;
  logic [1:0]     occ, satOcc;
  logic [15:0]    bubbleCnt;
  logic [1:0]     satCnt;

  ctrl_pipe_stages #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall),
    .flush(flush), .ctrl_out(ctrlOut), .valid_out(validOut), .occupancy(occ),
    .bubble_cnt(bubbleCnt)
  );

  ctrl_pipe_stages #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall),
    .flush(flush), .ctrl_out(satCtrlOut), .valid_out(satValidOut), .occupancy(satOcc),
    .bubble_cnt(satCnt)
  );

  // Clock and reset-time defaults
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; valid_in = 1'b0; ctrl_in = '0; stall = '0; flush = '0;
  end

  // Scoreboard state
  logic [SW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one entry per pipe stage
  logic         mV [S];
  logic [W-1:0] mC [S];
  int           mCnt = 0;
  int           mSat = 0;

  task automatic modelStep(input logic r, input logic v, input logic [W-1:0] c,
                           input logic [S-1:0] st, input logic [S-1:0] fl);
    logic         nV [S];
    logic [W-1:0] nC [S];
    logic [S-1:0] frozen;
    int           nb;
    nb = 0;
    if (r) begin
      for (int i = 0; i < S; i++) begin mV[i] = 1'b0; mC[i] = '0; end
      mCnt = 0;
      mSat = 0;
    end else begin
      // A stage is frozen if any stall at its index or later is raised
      for (int i = 0; i < S; i++) frozen[i] = |(st >> i);
      for (int i = 0; i < S; i++) begin
        if (fl[i]) begin
          nV[i] = 1'b0; nC[i] = '0;
        end else if (frozen[i]) begin
          nV[i] = mV[i]; nC[i] = mC[i];
        end else if (i > 0 && frozen[i-1]) begin
          nV[i] = 1'b0; nC[i] = '0; nb++;
        end else if (i == 0) begin
          nV[i] = v; nC[i] = v ? c : '0;
        end else begin
          nV[i] = mV[i-1]; nC[i] = mV[i-1] ? mC[i-1] : '0;
        end
      end
      for (int i = 0; i < S; i++) begin mV[i] = nV[i]; mC[i] = nC[i]; end
      mCnt = (mCnt + nb > 65535) ? 65535 : mCnt + nb;
      mSat = (mSat + nb > 3) ? 3 : mSat + nb;
    end
  endtask

  function automatic logic [SW-1:0] packExp();
    logic [1:0] o;
    o = 2'(mV[0]) + 2'(mV[1]) + 2'(mV[2]);
    return {mC[2], mC[1], mC[0], mV[2], mV[1], mV[0], o, 16'(mCnt), 2'(mSat)};
  endfunction

  // Driver: inputs change on the falling edge, expectation for the next rising edge is queued
  task automatic step(input logic r, input logic v, input logic [W-1:0] c,
                      input logic [S-1:0] st, input logic [S-1:0] fl);
    @(negedge clk);
    rst = r; valid_in = v; ctrl_in = c; stall = st; flush = fl;
    modelStep(r, v, c, st, fl);
    exp_q.push_back(packExp());
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: each rising edge presents a new set of registered taps
  initial begin
    logic [SW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ctrl_out",       64'(ctrlOut),     64'(e[58:23]));
        check("valid_out",      64'(validOut),    64'(e[22:20]));
        check("occupancy",      64'(occ),         64'(e[19:18]));
        check("bubble_cnt",     64'(bubbleCnt),   64'(e[17:2]));
        check("sat_bubble_cnt", 64'(satCnt),      64'(e[1:0]));
        check("sat_ctrl_out",   64'(satCtrlOut),  64'(e[58:23]));
        check("sat_valid_out",  64'(satValidOut), 64'(e[22:20]));
      end
    end
  end

  initial begin
    logic [S-1:0] st, fl;
    // Reset
    step(1, 0, 12'h000, 3'b000, 3'b000);
    step(1, 0, 12'h000, 3'b111, 3'b111);
    afterEdge();
    check("rst_ctrl", 64'(ctrlOut), 64'h0);
    check("rst_valid", 64'(validOut), 64'h0);
    check("rst_cnt", 64'(bubbleCnt), 64'h0);

    // Straight flow
    step(0, 1, 12'h041, 3'b000, 3'b000);
    afterEdge();
    check("flow_e_041", 64'(ctrlOut[11:0]), 64'h041);
    step(0, 1, 12'h052, 3'b000, 3'b000);
    step(0, 1, 12'h0C0, 3'b000, 3'b000);
    afterEdge();
    check("flow_full", 64'(ctrlOut), 64'h041_052_0C0);
    check("flow_occ", 64'(occ), 64'd3);
    check("flow_cnt", 64'(bubbleCnt), 64'd0);

    // stall[1]: E and M hold, W takes a bubble
    step(0, 1, 12'h0A5, 3'b010, 3'b000);
    afterEdge();
    check("stallm_ctrl", 64'(ctrlOut), 64'h000_052_0C0);
    check("stallm_valid", 64'(validOut), 64'b011);
    check("stallm_cnt", 64'(bubbleCnt), 64'd1);

    // flush[0] with stall[0]: E clears, M bubbles, W advances
    step(0, 1, 12'h0A6, 3'b001, 3'b001);
    afterEdge();
    check("flushstall_ctrl", 64'(ctrlOut), 64'h052_000_000);
    check("flushstall_valid", 64'(validOut), 64'b100);
    check("flushstall_cnt", 64'(bubbleCnt), 64'd2);

    // E=052, M=041, then stall[0] for two cycles
    step(0, 1, 12'h041, 3'b000, 3'b000);
    step(0, 1, 12'h052, 3'b000, 3'b000);
    step(0, 1, 12'h077, 3'b001, 3'b000);
    afterEdge();
    check("stalle1_ctrl", 64'(ctrlOut), 64'h041_000_052);
    step(0, 1, 12'h077, 3'b001, 3'b000);
    afterEdge();
    check("stalle2_ctrl", 64'(ctrlOut), 64'h000_000_052);
    check("stalle2_valid", 64'(validOut), 64'b001);
    check("stalle2_cnt", 64'(bubbleCnt), 64'd4);
    check("stalle2_sat", 64'(satCnt), 64'd3);

    // Invalid all-ones word is masked
    step(0, 0, 12'hFFF, 3'b000, 3'b000);
    afterEdge();
    check("invalid_ctrl", 64'(ctrlOut), 64'h000_052_000);
    check("invalid_valid", 64'(validOut), 64'b010);

    // Fifth hold-bubble: saturated copy stays at 3
    step(0, 1, 12'h0AA, 3'b001, 3'b000);
    afterEdge();
    check("sat5_cnt", 64'(bubbleCnt), 64'd5);
    check("sat5_sat", 64'(satCnt), 64'd3);

    // Fill, reset mid-stream, resume
    step(0, 1, 12'h011, 3'b000, 3'b000);
    step(0, 1, 12'h022, 3'b000, 3'b000);
    step(0, 1, 12'h033, 3'b000, 3'b000);
    step(1, 1, 12'h044, 3'b111, 3'b111);
    afterEdge();
    check("midrst_ctrl", 64'(ctrlOut), 64'h0);
    check("midrst_valid", 64'(validOut), 64'h0);
    check("midrst_sat", 64'(satCnt), 64'h0);
    step(0, 1, 12'h055, 3'b000, 3'b000);
    afterEdge();
    check("resume_e", 64'(ctrlOut), 64'h000_000_055);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < S; b++) begin
        st[b] = ($urandom_range(0, 3) == 0);
        fl[b] = ($urandom_range(0, 7) == 0);
      end
      step($urandom_range(0, 199) == 0, 1'($urandom), 12'($urandom), st, fl);
    end

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) afterEdge();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
